// File: rtl/fib_check_sequencer_if.sv
// Request/result handshake bundle for the Fibonacci check sequencer.
// The requester owns start/word/abort; the sequencer owns status and result.
interface fib_check_sequencer_if #(
   parameter int IDX_W = 5
);
   logic             start;
   logic [31:0]      user_word;
   logic             abort;
   logic             ready;
   logic             busy;
   logic             done;
   logic             win;
   logic [IDX_W-1:0] fail_index;

   modport master (
      output start, user_word, abort,
      input  ready, busy, done, win, fail_index
   );

   modport slave (
      input  start, user_word, abort,
      output ready, busy, done, win, fail_index
   );
endinterface

// File: rtl/fib_check_sequencer.sv
// Sequencer for the 4-bit Fibonacci check datapath: one pass per request,
// comparing the datapath sequence bit against a latched candidate word.
module fib_check_sequencer #(
   parameter int N_BITS      = 32,
   parameter int IDX_W       = 5,
   parameter bit EARLY_ABORT = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   fib_check_sequencer_if.slave bus,
   output logic                 dp_init,
   output logic                 dp_en_r1,
   output logic                 dp_en_r2,
   output logic [IDX_W-1:0]     dp_idx,
   input  logic                 dp_bit
);

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic [31:0]      word_q;
   logic             mis_q;
   logic [IDX_W-1:0] first_q;
   logic             win_q;
   logic [IDX_W-1:0] fail_q;

   logic accept;
   logic mis_now;
   logic last;
   logic to_done;
   logic ready;
   logic busy;
   logic done;

   assign accept  = (state_q == IDLE) && bus.start;
   assign mis_now = (state_q == RUN) && (dp_bit != word_q[idx_q]);
   assign last    = (idx_q == IDX_W'(N_BITS - 1));
   assign to_done = (state_q == RUN) && (state_d == DONE);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ready    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      dp_init  = 1'b0;
      dp_en_r1 = 1'b0;
      dp_en_r2 = 1'b0;
      dp_idx   = '0;
      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (bus.start) begin
               state_d = INIT;
               idx_d   = '0;
            end
         end
         INIT: begin
            busy     = 1'b1;
            dp_init  = 1'b1;
            dp_en_r1 = 1'b1;
            idx_d    = '0;
            state_d  = bus.abort ? IDLE : RUN;
         end
         RUN: begin
            busy     = 1'b1;
            dp_idx   = idx_q;
            dp_en_r1 = idx_q[2];
            dp_en_r2 = ~idx_q[2];
            if (bus.abort) begin
               state_d = IDLE;
            end else if (last || (EARLY_ABORT && mis_now)) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Mismatch tracking is internal; the visible result moves only on DONE entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         mis_q   <= 1'b0;
         first_q <= '0;
         win_q   <= 1'b0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (accept) begin
            word_q  <= bus.user_word;
            mis_q   <= 1'b0;
            first_q <= '0;
            win_q   <= 1'b0;
            fail_q  <= '0;
         end else begin
            if (mis_now && !mis_q) begin
               mis_q   <= 1'b1;
               first_q <= idx_q;
            end
            if (to_done) begin
               win_q  <= ~(mis_q | mis_now);
               fail_q <= (mis_now && !mis_q) ? idx_q : first_q;
            end
         end
      end
   end

   assign bus.ready      = ready;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.win        = win_q;
   assign bus.fail_index = fail_q;

endmodule

// File: tb/tb_fib_check_sequencer.sv
// Scoreboard bench for fib_check_sequencer: early-abort and full-run
// instances driven against a pattern-lookup datapath model.
module tb_fib_check_sequencer;
   localparam int W = 5;
   localparam logic [31:0] P = 32'hA5A5A5A5;

   typedef struct {
      logic         w;
      logic [W-1:0] f;
      int           lat;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   fib_check_sequencer_if #(.IDX_W(W)) bus_a ();
   fib_check_sequencer_if #(.IDX_W(W)) bus_b ();

   logic         init_a, r1_a, r2_a, bit_a;
   logic         init_b, r1_b, r2_b, bit_b;
   logic [W-1:0] idx_a, idx_b;
   logic [31:0]  pat = P;

   assign bit_a = pat[idx_a];
   assign bit_b = pat[idx_b];

   fib_check_sequencer #(.N_BITS(32), .IDX_W(W), .EARLY_ABORT(1'b1)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a),
      .dp_init(init_a), .dp_en_r1(r1_a), .dp_en_r2(r2_a),
      .dp_idx(idx_a), .dp_bit(bit_a)
   );

   fib_check_sequencer #(.N_BITS(32), .IDX_W(W), .EARLY_ABORT(1'b0)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b),
      .dp_init(init_b), .dp_en_r1(r1_b), .dp_en_r2(r2_b),
      .dp_idx(idx_b), .dp_bit(bit_b)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t sb[$];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic go(input bit sel, input logic [31:0] w, output int acc);
      if (sel) begin
         bus_b.start = 1'b1;
         bus_b.user_word = w;
      end else begin
         bus_a.start = 1'b1;
         bus_a.user_word = w;
      end
      @(posedge clock);
      @(negedge clock);
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      acc = cyc - 1;
   endtask

   task automatic wait_done(input bit sel, input int acc, input int budget,
                            output int lat, output bit seen);
      seen = 1'b0;
      lat  = -1;
      for (int i = 0; i < budget; i++) begin
         if (sel ? bus_b.done : bus_a.done) begin
            seen = 1'b1;
            lat  = cyc - acc;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic test_reset;
      bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.user_word = '0;
      bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.user_word = '0;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({bus_a.ready, bus_a.busy, bus_a.done, bus_a.win} !== 4'b1000) begin
         n_bad++;
         $display("FAIL reset_status got %b want 1000",
                  {bus_a.ready, bus_a.busy, bus_a.done, bus_a.win});
      end
      n_cmp++;
      if ({init_a, r1_a, r2_a, idx_a, bus_a.fail_index} !== '0) begin
         n_bad++;
         $display("FAIL reset_dp got %b want 0",
                  {init_a, r1_a, r2_a, idx_a, bus_a.fail_index});
      end
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (bus_b.ready !== 1'b1 || bus_b.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_b got rdy=%b busy=%b want 1 0",
                  bus_b.ready, bus_b.busy);
      end
   endtask

   task automatic test_full_pass;
      int   acc, lat, runs, both, wexp;
      bit   seen;
      exp_t e;
      sb.push_back('{1'b1, W'(0), 34});
      go(1'b0, P, acc);
      runs = 0; both = 0; seen = 1'b0; lat = -1;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (bus_a.done) begin
            seen = 1'b1;
            lat  = cyc - acc;
         end else begin
            if (r1_a && r2_a) both++;
            if (init_a) begin
               n_cmp++;
               if (r1_a !== 1'b1 || idx_a !== '0) begin
                  n_bad++;
                  $display("FAIL init_ctl got r1=%b idx=%0d want 1 0", r1_a, idx_a);
               end
            end else if (bus_a.busy) begin
               wexp = ((runs / 4) % 2);
               n_cmp++;
               if (idx_a !== W'(runs) || r1_a !== wexp[0]) begin
                  n_bad++;
                  $display("FAIL run_idx got idx=%0d r1=%b want idx=%0d r1=%b",
                           idx_a, r1_a, runs, wexp[0]);
               end
               runs++;
            end
            @(negedge clock);
         end
      end
      e = sb.pop_front();
      n_cmp++;
      if (!seen || lat != e.lat) begin
         n_bad++;
         $display("FAIL full_lat got %0d want %0d", lat, e.lat);
      end
      n_cmp++;
      if (bus_a.win !== e.w) begin
         n_bad++;
         $display("FAIL full_win got %b want %b", bus_a.win, e.w);
      end
      n_cmp++;
      if (runs != 32 || both != 0) begin
         n_bad++;
         $display("FAIL full_runs got runs=%0d both=%0d want 32 0", runs, both);
      end
      @(negedge clock);
      n_cmp++;
      if (bus_a.ready !== 1'b1 || cyc - acc != 35) begin
         n_bad++;
         $display("FAIL full_ready got rdy=%b at %0d want 1 at 35",
                  bus_a.ready, cyc - acc);
      end
   endtask

   task automatic test_early_fail(input int k);
      int   acc, lat;
      bit   seen;
      exp_t e;
      logic [31:0] m;
      m = 32'h1 << k;
      sb.push_back('{1'b0, W'(k), k + 3});
      go(1'b0, P ^ m, acc);
      wait_done(1'b0, acc, 60, lat, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || lat != e.lat) begin
         n_bad++;
         $display("FAIL early_lat k=%0d got %0d want %0d", k, lat, e.lat);
      end
      n_cmp++;
      if (bus_a.win !== e.w || bus_a.fail_index !== e.f) begin
         n_bad++;
         $display("FAIL early_res k=%0d got win=%b idx=%0d want %b %0d",
                  k, bus_a.win, bus_a.fail_index, e.w, e.f);
      end
      @(negedge clock);
   endtask

   task automatic test_no_early_abort;
      int   acc, lat;
      bit   seen;
      exp_t e;
      sb.push_back('{1'b0, W'(8), 34});
      go(1'b1, P ^ 32'h00010100, acc);
      wait_done(1'b1, acc, 60, lat, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || lat != e.lat) begin
         n_bad++;
         $display("FAIL full_run_lat got %0d want %0d", lat, e.lat);
      end
      n_cmp++;
      if (bus_b.win !== e.w || bus_b.fail_index !== e.f) begin
         n_bad++;
         $display("FAIL full_run_res got win=%b idx=%0d want %b %0d",
                  bus_b.win, bus_b.fail_index, e.w, e.f);
      end
      @(negedge clock);
   endtask

   task automatic test_abort;
      int acc, dones;
      bit hit;
      go(1'b0, P, acc);
      hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus_a.busy && !init_a && idx_a == W'(5)) begin
            hit = 1'b1;
            break;
         end
         @(negedge clock);
      end
      n_cmp++;
      if (!hit) begin
         n_bad++;
         $display("FAIL abort_reach got 0 want 1");
      end
      bus_a.abort = 1'b1;
      @(negedge clock);
      bus_a.abort = 1'b0;
      n_cmp++;
      if (bus_a.ready !== 1'b1 || bus_a.done !== 1'b0 || bus_a.win !== 1'b0
          || bus_a.fail_index !== '0) begin
         n_bad++;
         $display("FAIL abort_state got rdy=%b done=%b win=%b idx=%0d want 1 0 0 0",
                  bus_a.ready, bus_a.done, bus_a.win, bus_a.fail_index);
      end
      dones = 0;
      repeat (40) begin
         if (bus_a.done) dones++;
         @(negedge clock);
      end
      n_cmp++;
      if (dones != 0) begin
         n_bad++;
         $display("FAIL abort_done got %0d want 0", dones);
      end
   endtask

   task automatic test_start_while_busy;
      int   acc, lat;
      bit   seen;
      exp_t e;
      sb.push_back('{1'b1, W'(0), 34});
      go(1'b0, P, acc);
      repeat (4) @(negedge clock);
      bus_a.start = 1'b1;
      bus_a.user_word = 32'h0;
      @(negedge clock);
      bus_a.start = 1'b0;
      bus_a.user_word = P;
      wait_done(1'b0, acc, 60, lat, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || lat != e.lat || bus_a.win !== e.w) begin
         n_bad++;
         $display("FAIL busy_start got lat=%0d win=%b want %0d %b",
                  lat, bus_a.win, e.lat, e.w);
      end
      @(negedge clock);
   endtask

   task automatic test_back_to_back;
      int   acc, lat;
      bit   seen;
      exp_t e;
      sb.push_back('{1'b1, W'(0), 34});
      sb.push_back('{1'b0, W'(20), 35 + 23});
      bus_a.start = 1'b1;
      bus_a.user_word = P;
      @(posedge clock);
      @(negedge clock);
      acc = cyc - 1;
      wait_done(1'b0, acc, 60, lat, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || lat != e.lat || bus_a.win !== e.w) begin
         n_bad++;
         $display("FAIL b2b_first got lat=%0d win=%b want %0d %b",
                  lat, bus_a.win, e.lat, e.w);
      end
      @(negedge clock);
      bus_a.user_word = P ^ (32'h1 << 20);
      n_cmp++;
      if (bus_a.ready !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_ready got %b want 1", bus_a.ready);
      end
      @(negedge clock);
      bus_a.start = 1'b0;
      n_cmp++;
      if (bus_a.busy !== 1'b1 || bus_a.win !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_accept got busy=%b win=%b want 1 0",
                  bus_a.busy, bus_a.win);
      end
      wait_done(1'b0, acc, 60, lat, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || lat != e.lat || bus_a.win !== e.w || bus_a.fail_index !== e.f) begin
         n_bad++;
         $display("FAIL b2b_second got lat=%0d win=%b idx=%0d want %0d %b %0d",
                  lat, bus_a.win, bus_a.fail_index, e.lat, e.w, e.f);
      end
      @(negedge clock);
   endtask

   task automatic test_reset_mid_run;
      int acc, dones;
      bit hit;
      go(1'b0, P, acc);
      hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus_a.busy && !init_a && idx_a == W'(10)) begin
            hit = 1'b1;
            break;
         end
         @(negedge clock);
      end
      n_cmp++;
      if (!hit) begin
         n_bad++;
         $display("FAIL rst_reach got 0 want 1");
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (bus_a.busy !== 1'b0 || bus_a.ready !== 1'b1
          || {init_a, r1_a, r2_a, idx_a} !== '0) begin
         n_bad++;
         $display("FAIL rst_async got busy=%b rdy=%b dp=%b want 0 1 0",
                  bus_a.busy, bus_a.ready, {init_a, r1_a, r2_a, idx_a});
      end
      @(negedge clock);
      reset = 1'b0;
      dones = 0;
      repeat (40) begin
         if (bus_a.done) dones++;
         @(negedge clock);
      end
      n_cmp++;
      if (dones != 0 || bus_a.ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_after got dones=%0d rdy=%b want 0 1",
                  dones, bus_a.ready);
      end
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_abort();
      test_early_fail(0);
      test_early_fail(13);
      test_early_fail(31);
      test_no_early_abort();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fib_check_sequencer.md
# fib_check_sequencer

Control sequencer for the 4-bit Fibonacci-style check datapath (two alternating 4-bit registers feeding an adder, plus a bit-select compare against a 32-bit user word). It accepts a check request through a start/ready handshake and latches the candidate word. It then drives the datapath's init, register-enable and bit-index controls for one full pass and compares the datapath's sequence bit against the latched word each cycle. It reports pass (`win`) or the first failing bit index through a one-cycle `done` pulse. It replaces the free-running counter pair, so a check can be re-run without a global reset.

## Interface

- `N_BITS`, default 32, number of bits compared per pass (2..32).
- `IDX_W`, default 5, width of bit index; `2**IDX_W >= N_BITS`.
- `EARLY_ABORT`, default 1, when 1 the pass ends on first mismatch; when 0 it always runs `N_BITS` cycles.

Ports:

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `user_word`  in  32  candidate; sampled on the accept edge only.
- `abort`  in  1  cancel a pass in progress.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in INIT and RUN.
- `done`  out  1  one-cycle pulse at end of pass (not on abort).
- `win`  out  1  result of the last completed pass; held until next accept.
- `fail_index`  out  IDX_W  first mismatching bit index; valid when `win`=0 after `done`.
- `dp_init`  out  1  datapath init (carry-in/seed) strobe.
- `dp_en_r1`  out  1  write-enable for datapath register r1.
- `dp_en_r2`  out  1  write-enable for datapath register r2; never high together with `dp_en_r1`.
- `dp_idx`  out  IDX_W  current bit index; `dp_idx[2:0]` selects the datapath bit.
- `dp_bit`  in  1  datapath sequence bit for `dp_idx` (combinational from datapath registers).

## Operation

- FSM states: IDLE, INIT, RUN, DONE.
- IDLE: `ready`=1. On `start`=1, latch `user_word` into `word_q`, clear `win`, and clear `fail_index` to 0. Go to INIT.
- INIT (1 cycle):
  - `dp_init`=1, `dp_en_r1`=1, `dp_idx`=0.
  - No compare.
  - Go to RUN with index=0.
- RUN: each cycle drives `dp_idx`=index.
  - `dp_en_r1` = index[2]; `dp_en_r2` = ~index[2].
  - Compare `dp_bit` against `word_q[index]`.
  - On mismatch with the mismatch flag not yet set: set the flag and capture `fail_index`=index. Later mismatches do not overwrite it.
  - If index = `N_BITS`-1, or (`EARLY_ABORT` and a mismatch this cycle): go to DONE.
  - Otherwise index increments by 1. Index never wraps inside a pass.
- DONE (1 cycle): `done`=1; `win` = ~mismatch flag; go to IDLE.
- `abort`=1 in INIT or RUN: go to IDLE next edge, with no `done`. `win` and `fail_index` are left at their cleared values (0, 0). `abort` is ignored in IDLE and DONE.
- `start` is ignored while `ready`=0. `start` and `abort` together in IDLE: `start` wins.
- Outputs in IDLE: `dp_init`=0, `dp_en_r1`=0, `dp_en_r2`=0, `dp_idx`=0.

## Timing

- Reset (async assert, sync release) values:
  - `ready`=1, `busy`=0, `done`=0, `win`=0, `fail_index`=0.
  - All `dp_*` outputs 0; state IDLE.
- Reset asserted mid-pass forces IDLE immediately, with no `done`.
- Accept edge = cycle 0. INIT during cycle 1. RUN during cycles 2 .. `N_BITS`+1. `done` high during cycle `N_BITS`+2. `ready` high again at cycle `N_BITS`+3. That is 35 cycles from accept to `ready` for a full pass at `N_BITS`=32.
- Early abort on mismatch at index k: `done` high during cycle k+3.
- `dp_bit` is sampled at the end of the same cycle `dp_idx` is driven (zero-latency datapath read). The datapath register write from `dp_en_*` takes effect at the following edge.
- `win` and `fail_index` change only on the accept edge (cleared) and the DONE entry edge.
- Back-to-back: `start` held high is re-accepted on the first cycle `ready`=1 after DONE.

## Test plan

- Reset: assert `reset` mid-RUN at index 10. Expect `busy`=0, `ready`=1, all `dp_*`=0 asynchronously, and no `done` afterwards.
- Full pass: bench datapath model returns `dp_bit`=`P[dp_idx]` with P=0xA5A5A5A5; `user_word`=0xA5A5A5A5. Expect `done` at accept+34, `win`=1, and exactly 32 RUN cycles with `dp_idx` 0..31 in order.
- Early fail: P as above, `user_word`=0xA5A5A5A4 (bit 0 differs), `EARLY_ABORT`=1. Expect `done` at accept+3, `win`=0, `fail_index`=0.
- No early abort: `EARLY_ABORT`=0, `user_word`=P^0x00010100. Expect `done` at accept+34, `win`=0, and `fail_index`=8 (first mismatch kept).
- Abort and handshake:
  - `abort` at RUN index 5: expect no `done`, `ready` next cycle, `win`=0.
  - `start` pulsed while `busy`: ignored, with `word_q` unchanged.
- Enable pattern check: `dp_en_r1` and `dp_en_r2` are never both high. `dp_en_r1`=1 exactly for indices 4-7, 12-15, 20-23, 28-31, and in INIT.
